// File: rtl/phase_cordic_atan2.sv
// Vectoring-mode CORDIC: atan2(im, re) and gain-scaled magnitude of a normalized
// Q2.29 pair, one micro-rotation per clock.
module phase_cordic_atan2 #(
  parameter int ITER = 24,
  parameter int IW   = 35
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] re_normalized,
  input  logic        re_normalized_en,
  input  logic [31:0] im_normalized,
  input  logic        im_normalized_en,
  output logic        in_ready,
  output logic [31:0] phase,
  output logic [31:0] magnitude,
  output logic        result_en,
  output logic        zero_flag,
  output logic        sync_err,
  output logic [15:0] drop_cnt
);

  localparam int ZW = 34;
  localparam logic signed [ZW-1:0] PI_Q     = 34'sd1686629713;
  localparam logic signed [ZW-1:0] HALFPI_Q = 34'sd843314857;

  typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_r, state_s;
  logic signed [IW-1:0]   x_r, y_r, x0_s, y0_s, re_ext_s, im_ext_s, x_sh_s, y_sh_s;
  logic signed [ZW-1:0]   z_r, z0_s, atan_s;
  logic [4:0]             iter_r;
  logic                   zero_int_r;
  logic                   accept_s, both_en_s;
  logic [31:0]            phase_r, magnitude_r;
  logic                   result_en_r, zero_flag_r, sync_err_r;
  logic [15:0]            drop_cnt_r;

  // round(atan(2^-i) * 2^29); beyond i=10 the table is 2^(29-i), rounding to 0 at i=30
  function automatic logic signed [ZW-1:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_rom = 34'sd421657428;
      5'd1:    atan_rom = 34'sd248918915;
      5'd2:    atan_rom = 34'sd131521918;
      5'd3:    atan_rom = 34'sd66762579;
      5'd4:    atan_rom = 34'sd33510843;
      5'd5:    atan_rom = 34'sd16771758;
      5'd6:    atan_rom = 34'sd8387925;
      5'd7:    atan_rom = 34'sd4194219;
      5'd8:    atan_rom = 34'sd2097141;
      5'd9:    atan_rom = 34'sd1048575;
      5'd10:   atan_rom = 34'sd524288;
      5'd30:   atan_rom = 34'sd0;
      5'd31:   atan_rom = 34'sd0;
      default: atan_rom = 34'sd1 <<< (5'd29 - idx);
    endcase
  endfunction

  function automatic logic [31:0] clamp_pi(input logic signed [ZW-1:0] z);
    logic signed [ZW-1:0] c;
    if (z > PI_Q) begin
      c = PI_Q;
    end else if (z < -PI_Q) begin
      c = -PI_Q;
    end else begin
      c = z;
    end
    return c[31:0];
  endfunction

  assign both_en_s = re_normalized_en & im_normalized_en;
  assign accept_s  = both_en_s & (state_r == IDLE);
  assign re_ext_s  = {{(IW-32){re_normalized[31]}}, re_normalized};
  assign im_ext_s  = {{(IW-32){im_normalized[31]}}, im_normalized};
  assign x_sh_s    = x_r >>> iter_r;
  assign y_sh_s    = y_r >>> iter_r;
  assign atan_s    = atan_rom(iter_r);

  // Pre-rotation by +/-90 degrees folds the left half-plane into the CORDIC convergence range
  always_comb begin
    x0_s = re_ext_s;
    y0_s = im_ext_s;
    z0_s = {ZW{1'b0}};
    if (!re_normalized[31]) begin
      x0_s = re_ext_s;
      y0_s = im_ext_s;
      z0_s = {ZW{1'b0}};
    end else if (!im_normalized[31]) begin
      x0_s = im_ext_s;
      y0_s = -re_ext_s;
      z0_s = HALFPI_Q;
    end else begin
      x0_s = -im_ext_s;
      y0_s = re_ext_s;
      z0_s = -HALFPI_Q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = ROT;
        else          state_s = IDLE;
      end
      ROT: begin
        if (iter_r == 5'(ITER - 1)) state_s = DONE;
        else                        state_s = ROT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // CORDIC datapath: capture, then one micro-rotation per clock from pre-edge x/y
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r        <= {IW{1'b0}};
      y_r        <= {IW{1'b0}};
      z_r        <= {ZW{1'b0}};
      iter_r     <= 5'd0;
      zero_int_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            x_r        <= x0_s;
            y_r        <= y0_s;
            z_r        <= z0_s;
            iter_r     <= 5'd0;
            zero_int_r <= (re_normalized == 32'd0) && (im_normalized == 32'd0);
          end
        end
        ROT: begin
          if (!y_r[IW-1]) begin
            x_r <= x_r + y_sh_s;
            y_r <= y_r - x_sh_s;
            z_r <= z_r + atan_s;
          end else begin
            x_r <= x_r - y_sh_s;
            y_r <= y_r + x_sh_s;
            z_r <= z_r - atan_s;
          end
          iter_r <= iter_r + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Result registers, updated only on the DONE edge and held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r     <= 32'd0;
      magnitude_r <= 32'd0;
      zero_flag_r <= 1'b0;
      result_en_r <= 1'b0;
    end else begin
      result_en_r <= (state_r == DONE);
      if (state_r == DONE) begin
        phase_r     <= zero_int_r ? 32'd0 : clamp_pi(z_r);
        magnitude_r <= zero_int_r ? 32'd0 : x_r[31:0];
        zero_flag_r <= zero_int_r;
      end
    end
  end

  // Input-protocol status: sticky strobe mismatch and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err_r <= 1'b0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (re_normalized_en != im_normalized_en) sync_err_r <= 1'b1;
      if (both_en_s && (state_r != IDLE) && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign phase     = phase_r;
  assign magnitude = magnitude_r;
  assign result_en = result_en_r;
  assign zero_flag = zero_flag_r;
  assign sync_err  = sync_err_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_phase_cordic_atan2.sv
// Directed bench for phase_cordic_atan2: real-arithmetic atan2/magnitude model,
// cycle-exact result scoreboard, and literal checks for the documented vectors.
module tb_phase_cordic_atan2;
  localparam int  ITER     = 24;
  localparam longint PI_Q  = 64'sd1686629713;
  localparam longint HPI_Q = 64'sd843314857;
  localparam longint TOL   = 64'sd256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] re_normalized = 32'd0, im_normalized = 32'd0;
  logic        re_normalized_en = 1'b0, im_normalized_en = 1'b0;
  logic        in_ready, result_en, zero_flag, sync_err;
  logic [31:0] phase, magnitude;
  logic [15:0] drop_cnt;

  phase_cordic_atan2 #(.ITER(ITER), .IW(35)) dut (
    .clk(clk), .rst_n(rst_n),
    .re_normalized(re_normalized), .re_normalized_en(re_normalized_en),
    .im_normalized(im_normalized), .im_normalized_en(im_normalized_en),
    .in_ready(in_ready), .phase(phase), .magnitude(magnitude),
    .result_en(result_en), .zero_flag(zero_flag), .sync_err(sync_err),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     due;
    longint ph;
    longint mag;
    bit     zf;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void chk(string nm, bit ok, longint act, longint req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic longint labs(longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint sph();
    return longint'($signed(phase));
  endfunction

  // Ideal atan2 and |v| times the ITER-stage CORDIC gain, in Q.29 LSBs
  function automatic exp_t model(int re, int im, int due);
    exp_t e;
    real  k = 1.0;
    for (int i = 0; i < ITER; i++) k = k * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    e.due = due;
    if (re == 0 && im == 0) begin
      e.ph = 0; e.mag = 0; e.zf = 1'b1;
    end else begin
      e.ph  = longint'($atan2(real'(im), real'(re)) * (2.0 ** 29));
      e.mag = longint'($sqrt(real'(re) * real'(re) + real'(im) * real'(im)) * k);
      e.zf  = 1'b0;
    end
    return e;
  endfunction

  // Every negedge: result_en must pulse exactly on scheduled cycles with model-matching data
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("result_en_pulse", result_en === 1'b1, longint'(result_en), 1);
      chk("phase_vs_model", labs(sph() - e.ph) <= TOL, sph(), e.ph);
      chk("phase_range", labs(sph()) <= PI_Q, sph(), PI_Q);
      chk("magnitude_vs_model", labs(longint'(magnitude) - e.mag) <= TOL, longint'(magnitude), e.mag);
      chk("zero_flag_vs_model", zero_flag === e.zf, longint'(zero_flag), longint'(e.zf));
    end else begin
      chk("result_en_idle", result_en === 1'b0, longint'(result_en), 0);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(int re, int im);
    step();
    re_normalized = re; im_normalized = im;
    re_normalized_en = 1'b1; im_normalized_en = 1'b1;
    chk("in_ready_before_accept", in_ready === 1'b1, longint'(in_ready), 1);
    sb.push_back(model(re, im, cyc + ITER + 2));
    step();
    re_normalized_en = 1'b0; im_normalized_en = 1'b0;
    chk("in_ready_busy", in_ready === 1'b0, longint'(in_ready), 0);
    repeat (ITER + 2) step();
  endtask

  task automatic chk_reset_state(string nm);
    chk({nm, "_phase"}, phase === 32'd0, longint'(phase), 0);
    chk({nm, "_magnitude"}, magnitude === 32'd0, longint'(magnitude), 0);
    chk({nm, "_result_en"}, result_en === 1'b0, longint'(result_en), 0);
    chk({nm, "_zero_flag"}, zero_flag === 1'b0, longint'(zero_flag), 0);
    chk({nm, "_sync_err"}, sync_err === 1'b0, longint'(sync_err), 0);
    chk({nm, "_drop_cnt"}, drop_cnt === 16'd0, longint'(drop_cnt), 0);
    chk({nm, "_in_ready"}, in_ready === 1'b1, longint'(in_ready), 1);
  endtask

  initial begin
    #1;
    chk_reset_state("reset");
    step();
    rst_n = 1'b1;
    step();

    // Documented vectors with literal expectations (outputs hold until the next DONE)
    send(32'h10000000, 32'h00000000);
    chk("lit_pos_real_phase", labs(sph()) <= TOL, sph(), 0);
    chk("lit_pos_real_mag", labs(longint'(magnitude) - 64'sd442048846) <= TOL, longint'(magnitude), 442048846);
    chk("lit_pos_real_zf", zero_flag === 1'b0, longint'(zero_flag), 0);
    send(32'h00000000, 32'h10000000);
    chk("lit_pos_imag_phase", labs(sph() - HPI_Q) <= TOL, sph(), HPI_Q);
    send(32'hF0000000, 32'h00000000);
    chk("lit_neg_real_phase", (sph() <= PI_Q) && (sph() >= PI_Q - TOL), sph(), PI_Q);
    send(32'hF0000000, 32'hF0000000);
    chk("lit_third_quad_phase", labs(sph() + 64'sd1264972285) <= TOL, sph(), -64'sd1264972285);
    send(32'h00000000, 32'hF0000000);
    chk("lit_neg_imag_phase", labs(sph() + HPI_Q) <= TOL, sph(), -HPI_Q);
    send(32'h00000000, 32'h00000000);
    chk("lit_zero_phase", phase === 32'd0, sph(), 0);
    chk("lit_zero_mag", magnitude === 32'd0, longint'(magnitude), 0);
    chk("lit_zero_zf", zero_flag === 1'b1, longint'(zero_flag), 1);

    // Assorted quadrants and near-full-scale magnitudes, checked against the model only
    send(32'h0999999A, 32'h16666666);
    send(32'hE6666666, 32'h06666666);
    send(32'h13333333, 32'hE3333334);
    send(32'hF8000000, 32'hE3333334);
    send(32'h1FFFFFFF, 32'h1FFFFFFF);
    send(32'hE0000001, 32'h1FFFFFFF);

    // Busy drop: second pair arrives three cycles after the first was accepted
    step();
    re_normalized = 32'h0C000000; im_normalized = 32'h04000000;
    re_normalized_en = 1'b1; im_normalized_en = 1'b1;
    sb.push_back(model(32'h0C000000, 32'h04000000, cyc + ITER + 2));
    step();
    re_normalized_en = 1'b0; im_normalized_en = 1'b0;
    step(); step();
    re_normalized = 32'h02000000; im_normalized = 32'hF4000000;
    re_normalized_en = 1'b1; im_normalized_en = 1'b1;
    step();
    re_normalized_en = 1'b0; im_normalized_en = 1'b0;
    chk("drop_cnt_one", drop_cnt === 16'd1, longint'(drop_cnt), 1);
    repeat (ITER + 2) step();

    // Strobe mismatch while idle: flagged, ignored, block stays ready
    re_normalized_en = 1'b1; im_normalized_en = 1'b0;
    step();
    re_normalized_en = 1'b0;
    chk("sync_err_set", sync_err === 1'b1, longint'(sync_err), 1);
    chk("in_ready_after_mismatch", in_ready === 1'b1, longint'(in_ready), 1);
    repeat (ITER + 4) step();
    chk("sync_err_sticky", sync_err === 1'b1, longint'(sync_err), 1);

    // Reset during iteration 10 aborts the operation without a result pulse
    re_normalized = 32'h08000000; im_normalized = 32'h08000000;
    re_normalized_en = 1'b1; im_normalized_en = 1'b1;
    step();
    re_normalized_en = 1'b0; im_normalized_en = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk_reset_state("midop_reset");
    step();
    rst_n = 1'b1;
    repeat (ITER + 4) step();
    chk("no_result_after_abort", phase === 32'd0, sph(), 0);
    send(32'h08000000, 32'h18000000);
    chk("post_reset_result_nonzero", magnitude !== 32'd0, longint'(magnitude), 1);

    step();
    chk("scoreboard_drained", sb.size() == 0, longint'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
